matrix_stream_ctrl: RTL and testbench

MATRIX_STREAM_CTRL -- requirements
Module: matrix_stream_ctrl

---
 rtl/matrix_stream_ctrl.sv | 124 ++++++++++++
 tb/tb_matrix_stream_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_ctrl.sv
// Load/settle/unload controller for a 2x2 matrix stream: collects four nibbles into
// matrix a, waits for an external multiply stage, then streams its results out.
module matrix_stream_ctrl #(
   parameter int OUT_SEL    = 0,
   parameter int SETTLE_CYC = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [3:0]  in_data,
   output logic        in_ready,
   output logic [15:0] a,
   input  logic [15:0] b_in,
   input  logic [15:0] r_in,
   output logic        out_valid,
   output logic [3:0]  out_data,
   output logic        out_last,
   input  logic        out_ready,
   output logic        busy
);

   localparam logic [1:0] S_LOAD   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_UNLOAD = 2'd2;

   localparam logic [2:0] LAST_IDX   = (OUT_SEL == 1) ? 3'd7 : 3'd3;
   localparam logic [1:0] SETTLE_END = 2'(SETTLE_CYC - 1);

   logic [1:0]  state_q, state_d;
   logic [1:0]  ld_cnt_q, ld_cnt_d;
   logic [1:0]  st_cnt_q, st_cnt_d;
   logic [2:0]  un_cnt_q, un_cnt_d;
   logic [15:0] a_q, a_d;
   logic [15:0] r_hold_q, r_hold_d;
   logic [15:0] b_hold_q, b_hold_d;
   logic [15:0] sel_word;
   logic [3:0]  sel_nib;

   // Handshake: an element moves when valid and ready are both high at a rising
   // edge; ready never depends on valid on either side of this block.
   assign in_ready  = (state_q == S_LOAD) && !rst;
   assign out_valid = (state_q == S_UNLOAD);
   assign out_last  = out_valid && (un_cnt_q == LAST_IDX);
   assign busy      = (state_q != S_LOAD) || (ld_cnt_q != 2'd0);
   assign a         = a_q;

   always_comb begin
      state_d  = state_q;
      ld_cnt_d = ld_cnt_q;
      st_cnt_d = st_cnt_q;
      un_cnt_d = un_cnt_q;
      a_d      = a_q;
      r_hold_d = r_hold_q;
      b_hold_d = b_hold_q;
      case (state_q)
         S_LOAD: begin
            if (in_valid && in_ready) begin
               case (ld_cnt_q)
                  2'd0:    a_d[15:12] = in_data;
                  2'd1:    a_d[11:8]  = in_data;
                  2'd2:    a_d[7:4]   = in_data;
                  default: a_d[3:0]   = in_data;
               endcase
               ld_cnt_d = ld_cnt_q + 2'd1;
               if (ld_cnt_q == 2'd3) state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (st_cnt_q == SETTLE_END) begin
               st_cnt_d = 2'd0;
               r_hold_d = r_in;
               b_hold_d = b_in;
               state_d  = S_UNLOAD;
            end else begin
               st_cnt_d = st_cnt_q + 2'd1;
            end
         end
         S_UNLOAD: begin
            if (out_ready) begin
               if (un_cnt_q == LAST_IDX) begin
                  un_cnt_d = 3'd0;
                  state_d  = S_LOAD;
               end else begin
                  un_cnt_d = un_cnt_q + 3'd1;
               end
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   // With OUT_SEL=1 the first four indices come from the transpose, the rest from r.
   always_comb begin
      sel_word = ((OUT_SEL == 1) && !un_cnt_q[2]) ? b_hold_q : r_hold_q;
      case (un_cnt_q[1:0])
         2'd0:    sel_nib = sel_word[15:12];
         2'd1:    sel_nib = sel_word[11:8];
         2'd2:    sel_nib = sel_word[7:4];
         default: sel_nib = sel_word[3:0];
      endcase
      out_data = out_valid ? sel_nib : 4'h0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_LOAD;
         ld_cnt_q <= 2'd0;
         st_cnt_q <= 2'd0;
         un_cnt_q <= 3'd0;
         a_q      <= 16'h0000;
         r_hold_q <= 16'h0000;
         b_hold_q <= 16'h0000;
      end else begin
         state_q  <= state_d;
         ld_cnt_q <= ld_cnt_d;
         st_cnt_q <= st_cnt_d;
         un_cnt_q <= un_cnt_d;
         a_q      <= a_d;
         r_hold_q <= r_hold_d;
         b_hold_q <= b_hold_d;
      end
   end

endmodule

// File: tb/tb_matrix_stream_ctrl.sv
// Bench for matrix_stream_ctrl: two instances (OUT_SEL=0/SETTLE_CYC=1 and
// OUT_SEL=1/SETTLE_CYC=3) fed with directed and random frames.
module tb_matrix_stream_ctrl;

   localparam int OSEL0 = 0;
   localparam int SC0   = 1;
   localparam int OSEL1 = 1;
   localparam int SC1   = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid  [2];
   logic [3:0]  in_data   [2];
   logic        in_ready  [2];
   logic [15:0] a         [2];
   logic [15:0] b_in      [2];
   logic [15:0] r_in      [2];
   logic        out_valid [2];
   logic [3:0]  out_data  [2];
   logic        out_last  [2];
   logic        out_ready [2];
   logic        busy      [2];

   logic        rnd_rdy [2];
   logic        man_rdy [2];
   logic        rnd_bit [2];

   // {a expected, last, data}
   logic [20:0] exp_q0[$];
   logic [20:0] exp_q1[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t4 [2];
   int pops [2];
   logic prev_valid [2];
   logic stalled [2];
   logic [3:0] prev_data [2];
   logic prev_last [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   matrix_stream_ctrl #(.OUT_SEL(OSEL0), .SETTLE_CYC(SC0)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(in_data[0]),
      .in_ready(in_ready[0]), .a(a[0]), .b_in(b_in[0]), .r_in(r_in[0]),
      .out_valid(out_valid[0]), .out_data(out_data[0]), .out_last(out_last[0]),
      .out_ready(out_ready[0]), .busy(busy[0]));

   matrix_stream_ctrl #(.OUT_SEL(OSEL1), .SETTLE_CYC(SC1)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(in_data[1]),
      .in_ready(in_ready[1]), .a(a[1]), .b_in(b_in[1]), .r_in(r_in[1]),
      .out_valid(out_valid[1]), .out_data(out_data[1]), .out_last(out_last[1]),
      .out_ready(out_ready[1]), .busy(busy[1]));

   // External multiply stage: transpose and truncated A*A^T from the presented a.
   function automatic logic [15:0] env_t(input logic [15:0] m);
      return {m[15:12], m[7:4], m[11:8], m[3:0]};
   endfunction

   function automatic logic [15:0] env_r(input logic [15:0] m);
      int e0, e1, e2, e3, p00, p01, p11;
      e0 = int'(m[15:12]); e1 = int'(m[11:8]); e2 = int'(m[7:4]); e3 = int'(m[3:0]);
      p00 = e0 * e0 + e1 * e1;
      p01 = e0 * e2 + e1 * e3;
      p11 = e2 * e2 + e3 * e3;
      return {4'(p00), 4'(p01), 4'(p01), 4'(p11)};
   endfunction

   assign b_in[0] = env_t(a[0]);
   assign r_in[0] = env_r(a[0]);
   assign b_in[1] = env_t(a[1]);
   assign r_in[1] = env_r(a[1]);
   assign out_ready[0] = rnd_rdy[0] ? rnd_bit[0] : man_rdy[0];
   assign out_ready[1] = rnd_rdy[1] ? rnd_bit[1] : man_rdy[1];

   always @(posedge clk) begin
      #1;
      rnd_bit[0] = ($urandom_range(0, 3) != 0);
      rnd_bit[1] = ($urandom_range(0, 2) != 0);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int qsize(input int u);
      return (u == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   // Reference model: matrix-level definition of the output frame.
   task automatic push_expected(input int u, input logic [15:0] frame);
      int m [2][2];
      int vals [$];
      int osel;
      logic [20:0] e;
      osel = (u == 0) ? OSEL0 : OSEL1;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            m[i][j] = int'((frame >> (12 - 4 * (2 * i + j))) & 16'hF);
      if (osel == 1)
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
               vals.push_back(m[j][i]);
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            int s;
            s = 0;
            for (int k = 0; k < 2; k++) s += m[i][k] * m[j][k];
            vals.push_back(s % 16);
         end
      for (int n = 0; n < vals.size(); n++) begin
         e = {frame, (n == vals.size() - 1), 4'(vals[n])};
         if (u == 0) exp_q0.push_back(e);
         else exp_q1.push_back(e);
      end
   endtask

   task automatic mon(input int u);
      logic [20:0] e;
      int sc;
      sc = (u == 0) ? SC0 : SC1;
      if (rst) begin
         prev_valid[u] = 1'b0;
         stalled[u] = 1'b0;
      end else begin
         if (out_valid[u]) begin
            chk("in_ready_while_unloading", 32'(in_ready[u]), 32'd0);
            chk("busy_while_unloading", 32'(busy[u]), 32'd1);
            if (!prev_valid[u]) chk("first_out_latency", 32'(cyc - t4[u]), 32'(sc + 1));
            if (stalled[u]) begin
               chk("stall_data_stable", 32'(out_data[u]), 32'(prev_data[u]));
               chk("stall_last_stable", 32'(out_last[u]), 32'(prev_last[u]));
            end
            if (out_ready[u]) begin
               if (qsize(u) == 0) begin
                  chk("unexpected_output", 32'd1, 32'd0);
               end else begin
                  if (u == 0) e = exp_q0.pop_front();
                  else e = exp_q1.pop_front();
                  chk("out_data", 32'(out_data[u]), 32'(e[3:0]));
                  chk("out_last", 32'(out_last[u]), 32'(e[4]));
                  chk("a_held", 32'(a[u]), 32'(e[20:5]));
               end
               pops[u]++;
            end
         end else if (stalled[u]) begin
            chk("valid_dropped_during_stall", 32'd0, 32'd1);
         end
         stalled[u] = out_valid[u] && !out_ready[u];
         prev_valid[u] = out_valid[u];
         prev_data[u] = out_data[u];
         prev_last[u] = out_last[u];
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   // Gaps: one nibble per element, idle cycles inserted before that element.
   task automatic send_frame(input int u, input logic [15:0] frame, input logic [15:0] gaps,
                             input bit junk);
      int n;
      int sc;
      sc = (u == 0) ? SC0 : SC1;
      push_expected(u, frame);
      for (int i = 0; i < 4; i++) begin
         in_valid[u] = 1'b0;
         for (int g = 0; g < int'((gaps >> (12 - 4 * i)) & 16'hF); g++) begin
            @(posedge clk); #1;
         end
         in_valid[u] = 1'b1;
         in_data[u] = 4'(frame >> (12 - 4 * i));
         n = 0;
         while (!in_ready[u] && n < 300) begin
            @(posedge clk); #1;
            n++;
         end
         if (!in_ready[u]) chk("in_ready_timeout", 32'd0, 32'd1);
         if (i == 3) t4[u] = cyc;
         @(posedge clk); #1;
         in_valid[u] = 1'b0;
         if (i == 0) chk("busy_after_first_accept", 32'(busy[u]), 32'd1);
      end
      chk("a_packed", 32'(a[u]), 32'(frame));
      if (junk) begin
         in_valid[u] = 1'b1;
         for (int k = 0; k < sc + 1; k++) begin
            in_data[u] = 4'($urandom_range(0, 15));
            chk("in_ready_low_after_frame", 32'(in_ready[u]), 32'd0);
            @(posedge clk); #1;
         end
         n = 0;
         while (!in_ready[u] && n < 300) begin
            in_data[u] = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            n++;
         end
         if (!in_ready[u]) chk("return_to_load_timeout", 32'd0, 32'd1);
         in_valid[u] = 1'b0;
      end
   endtask

   task automatic drain(input int u);
      int n;
      n = 0;
      while ((qsize(u) != 0 || out_valid[u]) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_queue_empty", 32'(qsize(u)), 32'd0);
   endtask

   task automatic check_reset_outputs(input int u);
      chk("rst_in_ready", 32'(in_ready[u]), 32'd0);
      chk("rst_out_valid", 32'(out_valid[u]), 32'd0);
      chk("rst_out_data", 32'(out_data[u]), 32'd0);
      chk("rst_out_last", 32'(out_last[u]), 32'd0);
      chk("rst_busy", 32'(busy[u]), 32'd0);
      chk("rst_a", 32'(a[u]), 32'd0);
   endtask

   task automatic random_frames(input int u, input int count);
      logic [15:0] gaps;
      rnd_rdy[u] = 1'b1;
      for (int f = 0; f < count; f++) begin
         gaps = 16'h0;
         for (int i = 0; i < 4; i++)
            gaps = (gaps << 4) | 16'($urandom_range(0, 2));
         send_frame(u, 16'($urandom_range(0, 65535)), gaps, 1'b1);
      end
      drain(u);
      rnd_rdy[u] = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int base, n;
      for (int u = 0; u < 2; u++) begin
         in_valid[u] = 1'b0;
         in_data[u] = 4'h0;
         rnd_rdy[u] = 1'b0;
         man_rdy[u] = 1'b1;
         rnd_bit[u] = 1'b1;
         t4[u] = 0;
         pops[u] = 0;
         prev_valid[u] = 1'b0;
         stalled[u] = 1'b0;
         prev_data[u] = 4'h0;
         prev_last[u] = 1'b0;
      end
      #1 rst = 1'b1;
      #1;
      check_reset_outputs(0);
      check_reset_outputs(1);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      chk("in_ready_after_reset", 32'(in_ready[0]), 32'd1);

      // Basic frame, F frame with truncation, then backpressure on element B.
      send_frame(0, 16'h1234, 16'h0000, 1'b1);
      drain(0);
      send_frame(0, 16'hFFFF, 16'h0000, 1'b1);
      drain(0);

      man_rdy[0] = 1'b0;
      send_frame(0, 16'h1234, 16'h0000, 1'b0);
      n = 0;
      while (!out_valid[0] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_first_element", 32'(out_data[0]), 32'h5);
      man_rdy[0] = 1'b1;
      @(posedge clk); #1;
      man_rdy[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("bp_hold_data", 32'(out_data[0]), 32'hB);
         chk("bp_hold_valid", 32'(out_valid[0]), 32'd1);
         @(posedge clk); #1;
      end
      man_rdy[0] = 1'b1;
      drain(0);

      // in_valid pattern 1,0,0,1,1,0,1.
      send_frame(0, 16'h3A5C, 16'h0201, 1'b1);
      drain(0);

      // Reset in the middle of unloading after two elements.
      base = pops[0];
      send_frame(0, 16'h1234, 16'h0000, 1'b0);
      n = 0;
      while (pops[0] < base + 2 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("mid_unload_reached", 32'(out_valid[0]), 32'd1);
      exp_q0.delete();
      rst = 1'b1;
      #1;
      check_reset_outputs(0);
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      chk("in_ready_after_mid_reset", 32'(in_ready[0]), 32'd1);
      send_frame(0, 16'h2002, 16'h0000, 1'b1);
      drain(0);

      random_frames(0, 12);

      send_frame(1, 16'h1234, 16'h0000, 1'b1);
      drain(1);
      send_frame(1, 16'hFFFF, 16'h1010, 1'b1);
      drain(1);
      random_frames(1, 12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
